// File: rtl/receive_data.sv
// rtl/receive_data.sv - UART 8N1 receiver, 16x oversampling with 3-sample majority vote
// Define RX_PARITY_EN to receive 8E1 frames and report even-parity mismatches.
`timescale 1ns/1ps
module receive_data #(
  parameter int ClkFrequency          = 25000000,
  parameter int Baud                  = 9600,
  parameter int BaudGeneratorAccWidth = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       dataReady,
  output logic       frameError,
  output logic       parityError,
  output logic       rxdBusy
);
  localparam int W = BaudGeneratorAccWidth;
  localparam logic [63:0] INC_WIDE =
    ((64'(Baud) << (W + 4)) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
  localparam logic [W:0] INC = INC_WIDE[W:0];

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [W:0] r_acc;
  logic [1:0] r_sync;
  logic       r_prev;
  logic [3:0] r_sc;
  logic       r_s7;
  logic       r_s8;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_data_ready;
  logic       r_frame_error;
  logic       w_tick;
  logic       w_rx;
  logic       w_start_edge;
  logic       w_decide;
  logic       w_vote;
  logic       w_go;
  logic       w_bit_clr;
  logic       w_shift_en;
  logic       w_stop_good;
  logic       w_frame_err;
`ifdef RX_PARITY_EN
  logic       r_par_bit;
  logic       r_parity_error;
  logic       w_par_store;
  logic       w_par_err;
`endif

  assign w_tick       = r_acc[W];
  assign w_rx         = r_sync[1];
  assign w_start_edge = r_prev & ~w_rx;
  assign w_decide     = w_tick && (r_sc == 4'd9);
  assign w_vote       = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);

  assign data        = r_data;
  assign dataReady   = r_data_ready;
  assign frameError  = r_frame_error;
  assign rxdBusy     = (r_state != IDLE);
`ifdef RX_PARITY_EN
  assign parityError = r_parity_error;
`else
  assign parityError = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_acc  <= {1'b0, r_acc[W-1:0]} + INC;
      r_sync <= {r_sync[0], rxd};
      r_prev <= r_sync[1];
    end
  end

  // sc = 7 and 8 samples are held so the vote can complete on the sc = 9 tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sc <= 4'd0;
      r_s7 <= 1'b1;
      r_s8 <= 1'b1;
    end else begin
      if (w_go) begin
        r_sc <= 4'd0;
      end else if (w_tick) begin
        r_sc <= r_sc + 4'd1;
      end
      if (w_tick && r_sc == 4'd7) r_s7 <= w_rx;
      if (w_tick && r_sc == 4'd8) r_s8 <= w_rx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_go         = 1'b0;
    w_bit_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_stop_good  = 1'b0;
    w_frame_err  = 1'b0;
`ifdef RX_PARITY_EN
    w_par_store  = 1'b0;
    w_par_err    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_go         = 1'b1;
          w_next_state = START;
        end
      end
      START: begin
        if (w_decide) begin
          if (!w_vote) begin
            w_bit_clr    = 1'b1;
            w_next_state = DATA;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      DATA: begin
        if (w_decide) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
            w_next_state = PARITY;
`else
            w_next_state = STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (w_decide) begin
          w_par_store  = 1'b1;
          w_next_state = STOP;
        end
      end
`endif
      STOP: begin
        // leaving at mid-stop leaves half a bit to catch a back-to-back start edge
        if (w_decide) begin
          w_next_state = IDLE;
          if (!w_vote) begin
            w_frame_err = 1'b1;
`ifdef RX_PARITY_EN
          end else if (r_par_bit != ^r_shift) begin
            w_par_err   = 1'b1;
`endif
          end else begin
            w_stop_good = 1'b1;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'd0;
      r_data        <= 8'd0;
      r_data_ready  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      if (w_bit_clr) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_shift_en) r_shift <= {w_vote, r_shift[7:1]};
      if (w_stop_good) r_data <= r_shift;
      r_data_ready  <= w_stop_good;
      r_frame_error <= w_frame_err;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par_bit      <= 1'b0;
      r_parity_error <= 1'b0;
    end else begin
      if (w_par_store) r_par_bit <= w_vote;
      r_parity_error <= w_par_err;
    end
  end
`endif

endmodule

// File: tb/tb_receive_data.sv
// tb/tb_receive_data.sv - directed self-checking bench for receive_data (32 clk per bit)
`timescale 1ns/1ps
module tb_receive_data;
  localparam real BIT_NS  = 320.0;
  localparam real FAST_NS = 310.68;
  localparam real SLOW_NS = 329.90;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] data;
  logic       dataReady;
  logic       frameError;
  logic       parityError;
  logic       rxdBusy;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_ready = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         n_overlap = 0;
  time        t_ready = 0;
  time        t_fall = 0;
  logic [7:0] rx_q[$];

  receive_data #(
    .ClkFrequency(3200000),
    .Baud(100000),
    .BaudGeneratorAccWidth(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .data(data),
    .dataReady(dataReady),
    .frameError(frameError),
    .parityError(parityError),
    .rxdBusy(rxdBusy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dataReady) begin
      n_ready <= n_ready + 1;
      rx_q.push_back(data);
      t_ready <= $time;
    end
    if (frameError) n_ferr <= n_ferr + 1;
    if (parityError) n_perr <= n_perr + 1;
    if (32'(dataReady) + 32'(frameError) + 32'(parityError) > 1) n_overlap <= n_overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] q_at(input int idx);
    if (idx < rx_q.size()) return rx_q[idx];
    return 8'hxx;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns,
                            input bit with_par, input logic par_bit);
    rxd = 1'b0;
    t_fall = $time;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    if (with_par) begin
      rxd = par_bit;
      #(bit_ns);
    end
    rxd = stop_bit;
    #(bit_ns);
  endtask

  initial begin
    int         r0, f0, q0, busy_cnt, lat;
    logic [7:0] b;
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_ready", 32'(dataReady), 0);
    chk("rst_ferr", 32'(frameError), 0);
    chk("rst_perr", 32'(parityError), 0);
    chk("rst_busy", 32'(rxdBusy), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // two nominal frames
    r0 = n_ready; f0 = n_ferr;
    send_frame(8'h55, 1'b1, BIT_NS, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("t1_ready_55", 32'(n_ready - r0), 1);
    chk("t1_data_55", 32'(data), 32'h55);
    lat = int'((t_ready - t_fall) / 10);
    chk("t1_latency", 32'(lat >= 300 && lat <= 316), 1);
    repeat (64) @(negedge clk);
    send_frame(8'hA3, 1'b1, BIT_NS, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("t1_ready_a3", 32'(n_ready - r0), 2);
    chk("t1_data_a3", 32'(data), 32'hA3);
    chk("t1_ferr", 32'(n_ferr - f0), 0);

    // stop bit low
    repeat (64) @(negedge clk);
    r0 = n_ready; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, BIT_NS, 1'b0, 1'b0);
    rxd = 1'b1;
    repeat (64) @(negedge clk);
    chk("t2_ferr", 32'(n_ferr - f0), 1);
    chk("t2_ready", 32'(n_ready - r0), 0);
    chk("t2_data_held", 32'(data), 32'hA3);

    // 8-clk glitch
    r0 = n_ready; f0 = n_ferr; busy_cnt = 0;
    rxd = 1'b0;
    repeat (8) @(negedge clk) if (rxdBusy) busy_cnt++;
    rxd = 1'b1;
    repeat (60) @(negedge clk) if (rxdBusy) busy_cnt++;
    chk("t3_busy_seen", 32'(busy_cnt > 0), 1);
    chk("t3_busy_short", 32'(busy_cnt <= 32), 1);
    chk("t3_busy_end", 32'(rxdBusy), 0);
    chk("t3_ready", 32'(n_ready - r0), 0);
    chk("t3_ferr", 32'(n_ferr - f0), 0);

    // back-to-back frames, fast then slow sender
    for (int s = 0; s < 2; s++) begin
      real p;
      p = (s == 0) ? FAST_NS : SLOW_NS;
      repeat (64) @(negedge clk);
      r0 = n_ready; f0 = n_ferr; q0 = rx_q.size();
      send_frame(8'h00, 1'b1, p, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, p, 1'b0, 1'b0);
      send_frame(8'h81, 1'b1, p, 1'b0, 1'b0);
      repeat (16) @(negedge clk);
      chk("t4_ready_cnt", 32'(n_ready - r0), 3);
      chk("t4_byte0", 32'(q_at(q0)), 32'h00);
      chk("t4_byte1", 32'(q_at(q0 + 1)), 32'hFF);
      chk("t4_byte2", 32'(q_at(q0 + 2)), 32'h81);
      chk("t4_ferr", 32'(n_ferr - f0), 0);
    end

    // reset in bit 4 of 0xF0
    repeat (64) @(negedge clk);
    r0 = n_ready; f0 = n_ferr;
    b = 8'hF0;
    rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      #(BIT_NS);
    end
    rxd = b[4];
    #(BIT_NS / 2);
    reset = 1'b1;
    #30;
    chk("t5_busy_rst", 32'(rxdBusy), 0);
    chk("t5_data_rst", 32'(data), 32'h00);
    reset = 1'b0;
    rxd = 1'b1;
    #(BIT_NS * 5);
    chk("t5_no_ready", 32'(n_ready - r0), 0);
    chk("t5_no_ferr", 32'(n_ferr - f0), 0);
    send_frame(8'h12, 1'b1, BIT_NS, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("t5_ready_12", 32'(n_ready - r0), 1);
    chk("t5_data_12", 32'(data), 32'h12);

`ifdef RX_PARITY_EN
    repeat (64) @(negedge clk);
    r0 = n_ready; f0 = n_perr;
    send_frame(8'h07, 1'b1, BIT_NS, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    chk("t6_ready_good", 32'(n_ready - r0), 1);
    chk("t6_data_good", 32'(data), 32'h07);
    chk("t6_perr_good", 32'(n_perr - f0), 0);
    send_frame(8'h07, 1'b1, BIT_NS, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("t6_perr_bad", 32'(n_perr - f0), 1);
    chk("t6_ready_bad", 32'(n_ready - r0), 1);
`endif

    chk("no_overlap", 32'(n_overlap), 0);
    chk("perr_default", 32'(parityError), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
